dram_arbiter: RTL and testbench



---
 rtl/mem_pkg.sv | 6 +
 rtl/rr_pick.sv | 27 ++
 rtl/dram_arbiter.sv | 100 ++++++++++
 tb/tb_dram_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared DRAM widths and arbiter state encoding.
package mem_pkg;
   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 16;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority picker; search starts one past ptr_i and wraps, masked requests are skipped.
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   input  logic [N-1:0]     mask_i,
   output logic             found_o,
   output logic [IDX_W-1:0] idx_o
);
   function automatic logic [IDX_W-1:0] cand(input logic [IDX_W-1:0] ptr, input int k);
      return IDX_W'((int'(ptr) + k) % N);
   endfunction

   // Scan farthest-first so the nearest eligible candidate is the last one written.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      for (int k = N; k >= 1; k--) begin
         if (req_i[cand(ptr_i, k)] && !mask_i[cand(ptr_i, k)]) begin
            found_o = 1'b1;
            idx_o   = cand(ptr_i, k);
         end
      end
   end
endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin sharing of a single-port DRAM with one-cycle registered read latency;
// every access is an ACCESS cycle followed by a RESP cycle that carries the ack and read data.
module dram_arbiter
   import mem_pkg::*;
#(
   parameter int NUM_CORES  = 4,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   localparam int IDX_W     = $clog2(NUM_CORES)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_CORES-1:0]        core_req,
   input  logic [NUM_CORES-1:0]        core_we,
   input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
   input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
   output logic [NUM_CORES-1:0]        core_ack,
   output logic [DATA_W-1:0]           core_rdata,
   output logic                        busy,
   output logic                        mem_write_en,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_data_in,
   input  logic [DATA_W-1:0]           mem_data_out
);
   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       rr_q, rr_d, grant_q, grant_d, win;
   logic                   we_q, we_d, found;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [DATA_W-1:0]      din_q, din_d;
   logic [NUM_CORES-1:0]   ack_q, ack_d, mask;
   logic [ADDR_W-1:0]      addr_a  [NUM_CORES];
   logic [DATA_W-1:0]      wdata_a [NUM_CORES];

   for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
      assign addr_a[g]  = core_addr[g*ADDR_W +: ADDR_W];
      assign wdata_a[g] = core_wdata[g*DATA_W +: DATA_W];
   end

   // The acked core still holds req during RESP, so it must not win again.
   assign mask = (state_q == RESP) ? NUM_CORES'(1) << grant_q : '0;

   rr_pick #(.N(NUM_CORES), .IDX_W(IDX_W)) u_pick (
      .req_i   (core_req),
      .ptr_i   (rr_q),
      .mask_i  (mask),
      .found_o (found),
      .idx_o   (win)
   );

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      grant_d = grant_q;
      we_d    = we_q;
      addr_d  = addr_q;
      din_d   = din_q;
      ack_d   = '0;
      if (state_q == ACCESS) begin
         we_d           = 1'b0;
         ack_d[grant_q] = 1'b1;
         state_d        = RESP;
      end else if (found) begin
         state_d = ACCESS;
         rr_d    = win;
         grant_d = win;
         we_d    = core_we[win];
         addr_d  = addr_a[win];
         din_d   = wdata_a[win];
      end else begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rr_q    <= IDX_W'(NUM_CORES - 1);
         grant_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         ack_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         grant_q <= grant_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         ack_q   <= ack_d;
      end
   end

   assign core_ack     = ack_q;
   assign core_rdata   = mem_data_out;
   assign busy         = (state_q != IDLE);
   assign mem_write_en = we_q;
   assign mem_addr     = addr_q;
   assign mem_data_in  = din_q;
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: DRAM model plus transaction-level reference model for dram_arbiter.
module tb_dram_arbiter;
   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    core_req = '0, core_we = '0, core_ack;
   logic [N*AW-1:0] core_addr = '0;
   logic [N*DW-1:0] core_wdata = '0;
   logic [DW-1:0]   core_rdata, mem_data_in, mem_data_out;
   logic [AW-1:0]   mem_addr;
   logic            busy, mem_write_en;

   always #5 clk = ~clk;

   dram_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .core_req(core_req), .core_we(core_we),
      .core_addr(core_addr), .core_wdata(core_wdata), .core_ack(core_ack),
      .core_rdata(core_rdata), .busy(busy), .mem_write_en(mem_write_en),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
   );

   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      return a ^ 16'h5A5A;
   endfunction

   // Single-port DRAM: registered read, write on write_en.
   logic [DW-1:0] dram    [65536];
   bit            written [65536];
   always @(posedge clk) begin
      if (mem_write_en) begin
         dram[mem_addr]    <= mem_data_in;
         written[mem_addr] <= 1'b1;
      end
      mem_data_out <= written[mem_addr] ? dram[mem_addr] : init_val(mem_addr);
   end

   // Reference model state: an access is granted at an edge and acked two cycles later.
   logic [DW-1:0] shadow [65536];
   int            checks = 0, errors = 0;
   int            cyc = 0, last = N - 1, g = 0, ack_at = 0, last_acked = -1, we_cnt = 0;
   bit            pend = 0, chk_en = 0, g_we = 0;
   logic [AW-1:0] g_addr = '0;
   logic [DW-1:0] g_wd = '0, last_rdata = '0;
   logic [N-1:0]  sticky = '0;
   int            ack_log[$], ack_cyc[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int after, input int masked);
      for (int k = 1; k <= N; k++) begin
         int c = (after + k) % N;
         if (r[c] && c != masked) return c;
      end
      return -1;
   endfunction

   task automatic set_req(input int c, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      core_req[c]            = 1'b1;
      core_we[c]             = we;
      core_addr[c*AW +: AW]  = a;
      core_wdata[c*DW +: DW] = d;
   endtask

   task automatic step();
      int            acked, w;
      logic [N-1:0]  exp_ack;
      @(negedge clk);
      acked = (pend && cyc == ack_at) ? g : -1;
      last_acked = acked;
      if (mem_write_en === 1'b1) we_cnt++;
      if (chk_en) begin
         exp_ack = (acked >= 0) ? N'(1) << g : '0;
         check("ack", core_ack, exp_ack);
         check("busy", busy, pend);
         check("write_en", mem_write_en, pend && cyc == ack_at - 1 && g_we);
         if (pend && cyc == ack_at - 1) begin
            check("mem_addr", mem_addr, g_addr);
            if (g_we) check("mem_data_in", mem_data_in, g_wd);
         end
      end
      if (acked >= 0) begin
         ack_log.push_back(g);
         ack_cyc.push_back(cyc);
         last_rdata = core_rdata;
         if (g_we) shadow[g_addr] = g_wd;
         else check("rdata", core_rdata, shadow[g_addr]);
      end
      if (reset) begin
         if (pend && cyc == ack_at - 1 && g_we) shadow[g_addr] = g_wd;
         pend = 0;
         last = N - 1;
      end else if (!pend || acked >= 0) begin
         w = pick(core_req, last, acked);
         pend = (w >= 0);
         if (w >= 0) begin
            g      = w;
            ack_at = cyc + 2;
            last   = w;
            g_we   = core_we[w];
            g_addr = core_addr[w*AW +: AW];
            g_wd   = core_wdata[w*DW +: DW];
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (acked >= 0 && !sticky[acked]) core_req[acked] = 1'b0;
   endtask

   task automatic run_until_acks(input int n, input int budget, input string name);
      for (int i = 0; i < budget && ack_log.size() < n; i++) step();
      check({name, "_ack_count"}, ack_log.size(), n);
   endtask

   typedef struct {
      int            core;
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      logic [DW-1:0] exp_rd;
   } vec_t;
   vec_t tbl[8];

   initial begin
      int lat;
      bit got;
      for (int i = 0; i < 65536; i++) shadow[i] = init_val(16'(i));
      tbl[0] = '{1, 1'b1, 16'h0040, 16'hBEEF, 16'h0000};
      tbl[1] = '{1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF};
      tbl[2] = '{3, 1'b1, 16'h0100, 16'h0001, 16'h0000};
      tbl[3] = '{0, 1'b0, 16'h0100, 16'h0000, 16'h0001};
      tbl[4] = '{2, 1'b0, 16'h0007, 16'h0000, 16'h5A5D};
      tbl[5] = '{3, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000};
      tbl[6] = '{0, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF};
      tbl[7] = '{2, 1'b0, 16'h0000, 16'h0000, 16'h5A5A};

      step();
      step();
      reset = 1'b0;
      chk_en = 1;
      check("rst_ack", core_ack, 0);
      check("rst_we", mem_write_en, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_din", mem_data_in, 0);
      check("rst_busy", busy, 0);

      for (int i = 0; i < 10; i++) begin
         step();
         check("idle_quiet", {busy, core_ack, mem_write_en}, 0);
      end

      ack_log.delete(); ack_cyc.delete();
      for (int c = 0; c < N; c++) set_req(c, 1'b0, 16'(16'h0010 + c), '0);
      run_until_acks(4, 20, "all4");
      for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
         check("all4_order", ack_log[i], i);
         if (i > 0) check("all4_spacing", ack_cyc[i] - ack_cyc[i-1], 2);
      end
      step();

      foreach (tbl[i]) begin
         set_req(tbl[i].core, tbl[i].we, tbl[i].addr, tbl[i].wd);
         we_cnt = 0;
         lat = 0;
         got = 0;
         for (int k = 0; k < 10 && !got; k++) begin
            step();
            lat++;
            got = (last_acked == tbl[i].core);
         end
         check("tbl_ack_latency", lat, 3);
         check("tbl_we_cycles", we_cnt, tbl[i].we);
         if (!tbl[i].we) check("tbl_rdata", last_rdata, tbl[i].exp_rd);
      end

      set_req(1, 1'b0, 16'h0060, '0);
      run_until_acks(ack_log.size() + 1, 10, "prep1");
      ack_log.delete();
      sticky[2] = 1'b1;
      set_req(2, 1'b0, 16'h0030, '0);
      set_req(0, 1'b0, 16'h0031, '0);
      run_until_acks(3, 20, "hold");
      if (ack_log.size() >= 3) check("hold_order", {8'(ack_log[0]), 8'(ack_log[1]), 8'(ack_log[2])}, 32'h020002);
      sticky[2] = 1'b0;
      core_req[2] = 1'b0;
      step();

      set_req(0, 1'b0, 16'h0050, '0);
      run_until_acks(ack_log.size() + 1, 10, "prep0");
      ack_log.delete();
      set_req(1, 1'b1, 16'h0020, 16'hCAFE);
      set_req(2, 1'b0, 16'h0020, '0);
      run_until_acks(2, 12, "wr_rd");
      if (ack_log.size() >= 2) check("wr_rd_order", {8'(ack_log[0]), 8'(ack_log[1])}, 32'h0102);
      check("wr_rd_rdata", last_rdata, 16'hCAFE);
      step();

      set_req(2, 1'b1, 16'h0005, 16'h1234);
      step();
      reset = 1'b1;
      core_req = '0;
      step();
      reset = 1'b0;
      step();
      check("rst_mid_no_ack", core_ack, 0);
      ack_log.delete();
      set_req(0, 1'b0, 16'h0005, '0);
      set_req(3, 1'b0, 16'h0006, '0);
      run_until_acks(1, 10, "rst_mid");
      if (ack_log.size() >= 1) check("rst_mid_first", ack_log[0], 0);
      check("rst_mid_rdata", last_rdata, 16'h1234);
      run_until_acks(2, 10, "rst_mid2");

      for (int i = 0; i < 800; i++) begin
         step();
         for (int c = 0; c < N; c++)
            if (!core_req[c] && $urandom_range(2) == 0)
               set_req(c, 1'($urandom_range(1)),
                       ($urandom_range(9) == 0) ? 16'hFFFF : 16'($urandom_range(7)), 16'($urandom));
      end
      for (int i = 0; i < 40 && (pend || core_req != 0); i++) step();
      check("drain", {pend, core_req}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
